data_sequencer: RTL
===================

Name: data_sequencer

Overview:
- Controller that walks a data_medium through a training dataset: issues sample addresses in order, waits for each fetch, and hands (x, y) pairs to a downstream consumer over a valid/ready handshake.
- Repeats the sweep for a programmed number of epochs.
- Sits between the training CPU/control FSM and data_medium.
- Registered one-slot output buffer, so the next fetch overlaps consumption of the current sample.

Parameters:
- ADDRS, 1024, number of samples data_medium can hold. Derived ADDR_SIZE = $clog2(ADDRS).
- BRAM_WIDTH, 64, BRAM word width. Used only to size X_WIDTH.
- PIECES, 16, BRAM words per x (or y) vector. X_WIDTH = PIECES*BRAM_WIDTH.
- EPOCH_WIDTH, 16, width of the epoch counter.

Ports:
- clk_in  input  1  clock. All state on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- start_in  input  1  one-cycle start pulse. Sampled only in IDLE.
- abort_in  input  1  cancel the run. Any state returns to IDLE.
- num_samples_in  input  ADDR_SIZE+1  samples per epoch (0..ADDRS). Latched on start.
- num_epochs_in  input  EPOCH_WIDTH  number of epochs. Latched on start.
- busy_out  output  1  high from the cycle after an accepted start until the return to IDLE.
- done_out  output  1  one-cycle pulse when a run completes. No pulse on abort.
- medium_addr_out  output  ADDR_SIZE  address to data_medium addr_in.
- medium_x_in  input  X_WIDTH  data_medium x_out.
- medium_y_in  input  X_WIDTH  data_medium y_out.
- medium_finished_in  input  1  data_medium finished_out. x/y are valid for the current address while this is high.
- x_out  output  X_WIDTH  registered sample x.
- y_out  output  X_WIDTH  registered sample y.
- valid_out  output  1  x_out/y_out hold an unconsumed sample.
- ready_in  input  1  consumer accepts when valid_out && ready_in.
- last_out  output  1  qualifies valid_out: this sample is the final one of its epoch.
- epoch_out  output  EPOCH_WIDTH  epoch index of the sample on x_out/y_out.

Behaviour:
- Reset (rst_in low, asynchronous) forces:
  - state IDLE
  - all outputs 0
  - x_out, y_out, medium_addr_out = 0
  - internal counters 0
- Reset mid-run discards everything. No done_out is produced.
- States:
  - IDLE: busy_out=0. On start_in with num_samples_in!=0 and num_epochs_in!=0: latch the limits, set addr=0 and epoch=0, go to ISSUE. On start_in with either limit zero: go to FINISH (done_out pulses the next cycle, no samples issued). start_in outside IDLE is ignored.
  - ISSUE: exactly one cycle. medium_addr_out already holds the new address. medium_finished_in is ignored here because it may be stale. Go to WAIT.
  - WAIT: hold medium_addr_out stable. When medium_finished_in=1 and the slot is free (valid_out=0, or valid_out&&ready_in this cycle), capture in the same edge:
    - x, y into the output registers
    - last_out = (addr==num_samples-1)
    - epoch_out = current epoch
    - valid_out = 1

    Then advance:
    - If addr<num_samples-1: addr+1, go to ISSUE.
    - Else if epoch<num_epochs-1: addr=0, epoch+1, go to ISSUE.
    - Else go to DRAIN.

    If the slot is full, stay in WAIT.
  - DRAIN: wait until valid_out clears (consumer accepts the final sample), then go to FINISH.
  - FINISH: done_out=1 for one cycle, go to IDLE.
- Latency: start accepted at edge 0, ISSUE at edge 1, WAIT at edge 2. With finished already high, valid_out rises at edge 3. Back-to-back throughput is one sample per 2 cycles (ISSUE + WAIT) when the consumer is always ready.
- Output handshake: x_out, y_out, last_out and epoch_out are stable while valid_out && !ready_in. valid_out clears on accept unless a new capture happens on the same edge, in which case it stays 1 with the new data.
- Abort: next state IDLE, valid_out=0, no done_out. Abort has priority over start and capture when they occur on the same edge.
- Width rules:
  - num_samples_in==ADDRS is legal. The last addr is ADDRS-1, and addr never wraps past it.
  - Epoch counter comparisons use the full EPOCH_WIDTH.
  - No overflow is possible because the limits are latched values.

Decomposition:
- Package data_seq_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DRAIN, FINISH)
  - a function computing X_WIDTH from BRAM_WIDTH and PIECES.
- Natural sub-module: sample_slot. It is the one-entry valid/ready output register holding {x, y, last, epoch}, with capture, accept and clear inputs and a slot_free output.
- The FSM and counters stay in data_sequencer.

Test Plan:
- Basic run: num_samples=3, num_epochs=1, medium_finished held 1, ready_in=1 → medium_addr_out sequence 0,1,2; three accepts; last_out only on addr 2; done_out pulses once; busy_out low after.
- Epochs: num_samples=2, num_epochs=3, finished=1, ready=1 → six samples; epoch_out 0,0,1,1,2,2; last_out on the 2nd, 4th and 6th; addr wraps to 0 between epochs.
- Backpressure: ready_in=0 for 10 cycles after first valid → x_out/y_out/valid_out stable; FSM parks in WAIT with medium_addr_out=1; after ready_in=1, sample 1 follows with no loss or duplication.
- Slow medium: finished deasserted for 5 cycles after each address change (model data_medium latency) → each capture occurs only after finished rises; stale finished high during ISSUE is never captured.
- Zero limits and abort: start with num_samples=0 → done_out 2 cycles later, valid_out never set. Start 4/1, then abort_in on the 2nd sample → IDLE, valid_out=0, no done_out.
- Async reset: assert rst_in low mid-WAIT between clock edges → outputs 0 immediately; after release, start_in is accepted normally.

Source files
------------

// File: rtl/data_seq_pkg.sv
// Shared types and helpers for the data sequencer: FSM state encoding and
// the x/y vector width derived from the BRAM geometry.
package data_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } state_t;

  function automatic int x_width(input int bram_width, input int pieces);
    return bram_width * pieces;
  endfunction

endpackage

// File: rtl/sample_slot.sv
// One-entry valid/ready output register holding {x, y, last, epoch}.
// A capture may land on the same edge as an accept, keeping the slot full.
module sample_slot #(
  parameter int X_WIDTH     = 1024,
  parameter int EPOCH_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   capture,
  input  logic                   accept,
  input  logic [X_WIDTH-1:0]     x_new,
  input  logic [X_WIDTH-1:0]     y_new,
  input  logic                   last_new,
  input  logic [EPOCH_WIDTH-1:0] epoch_new,
  output logic [X_WIDTH-1:0]     x,
  output logic [X_WIDTH-1:0]     y,
  output logic                   last,
  output logic [EPOCH_WIDTH-1:0] epoch,
  output logic                   valid,
  output logic                   slot_free
);

  assign slot_free = !valid || accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= '0;
      y     <= '0;
      last  <= 1'b0;
      epoch <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      x     <= x_new;
      y     <= y_new;
      last  <= last_new;
      epoch <= epoch_new;
      valid <= 1'b1;
    end else if (valid && accept) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/data_sequencer.sv
// Walks data_medium through samples 0..num_samples-1 for num_epochs epochs,
// handing each fetched (x, y) pair to a consumer through a one-entry buffer.
module data_sequencer
  import data_seq_pkg::*;
#(
  parameter  int ADDRS       = 1024,
  parameter  int BRAM_WIDTH  = 64,
  parameter  int PIECES      = 16,
  parameter  int EPOCH_WIDTH = 16,
  localparam int ADDR_SIZE   = $clog2(ADDRS),
  localparam int X_WIDTH     = x_width(BRAM_WIDTH, PIECES)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic                   abort_in,
  input  logic [ADDR_SIZE:0]     num_samples_in,
  input  logic [EPOCH_WIDTH-1:0] num_epochs_in,
  output logic                   busy_out,
  output logic                   done_out,
  output logic [ADDR_SIZE-1:0]   medium_addr_out,
  input  logic [X_WIDTH-1:0]     medium_x_in,
  input  logic [X_WIDTH-1:0]     medium_y_in,
  input  logic                   medium_finished_in,
  output logic [X_WIDTH-1:0]     x_out,
  output logic [X_WIDTH-1:0]     y_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   last_out,
  output logic [EPOCH_WIDTH-1:0] epoch_out
);

  state_t                 state, state_d;
  logic [ADDR_SIZE-1:0]   addr, addr_d;
  logic [EPOCH_WIDTH-1:0] epoch, epoch_d;
  logic [ADDR_SIZE:0]     num_samples, num_samples_d;
  logic [EPOCH_WIDTH-1:0] num_epochs, num_epochs_d;
  logic                   capture;
  logic                   slot_free;
  logic                   addr_last;
  logic                   epoch_last;

  // Full-width compares so num_samples == ADDRS stops at ADDRS-1 without wrapping
  assign addr_last  = ({1'b0, addr} == (num_samples - (ADDR_SIZE + 1)'(1)));
  assign epoch_last = (epoch == (num_epochs - EPOCH_WIDTH'(1)));

  assign medium_addr_out = addr;
  assign busy_out        = (state != IDLE);
  assign done_out        = (state == FINISH);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      addr        <= '0;
      epoch       <= '0;
      num_samples <= '0;
      num_epochs  <= '0;
    end else begin
      state       <= state_d;
      addr        <= addr_d;
      epoch       <= epoch_d;
      num_samples <= num_samples_d;
      num_epochs  <= num_epochs_d;
    end
  end

  always_comb begin
    state_d       = state;
    addr_d        = addr;
    epoch_d       = epoch;
    num_samples_d = num_samples;
    num_epochs_d  = num_epochs;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) begin
          if ((num_samples_in != '0) && (num_epochs_in != '0)) begin
            num_samples_d = num_samples_in;
            num_epochs_d  = num_epochs_in;
            addr_d        = '0;
            epoch_d       = '0;
            state_d       = ISSUE;
          end else begin
            state_d = FINISH;
          end
        end
      end
      // finished may still reflect the previous address here, so never sample it
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (medium_finished_in && slot_free) begin
          capture = 1'b1;
          if (!addr_last) begin
            addr_d  = addr + ADDR_SIZE'(1);
            state_d = ISSUE;
          end else if (!epoch_last) begin
            addr_d  = '0;
            epoch_d = epoch + EPOCH_WIDTH'(1);
            state_d = ISSUE;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN:   if (!valid_out) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_in) begin
      state_d = IDLE;
      capture = 1'b0;
    end
  end

  sample_slot #(
    .X_WIDTH    (X_WIDTH),
    .EPOCH_WIDTH(EPOCH_WIDTH)
  ) u_slot (
    .clk      (clk_in),
    .rst_n    (rst_in),
    .clear    (abort_in),
    .capture  (capture),
    .accept   (ready_in),
    .x_new    (medium_x_in),
    .y_new    (medium_y_in),
    .last_new (addr_last),
    .epoch_new(epoch),
    .x        (x_out),
    .y        (y_out),
    .last     (last_out),
    .epoch    (epoch_out),
    .valid    (valid_out),
    .slot_free(slot_free)
  );

endmodule
